serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor: one registered full-subtractor/full-adder cell, reused LSB-first over WIDTH cycles.
- Computes a-b (or a+b) on WIDTH-bit operands; reports unsigned borrow/carry and signed overflow.
- Start/busy/done handshake; sits in the arithmetic datapath where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = subtract (a-b), 1 = add (a+b); latched with start.
- a  input  WIDTH  minuend/addend; latched with start.
- b  input  WIDTH  subtrahend/addend; latched with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when result valid.
- diff  output  WIDTH  result; holds until next accepted start.
- borrow_out  output  1  sub: final borrow (a<b unsigned); add: carry out.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, diff, borrow_out, overflow, shift regs, counter, borrow/carry reg all 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> load a, b, mode into shift regs; borrow/carry reg=0; counter=0; state=RUN; busy=1 after edge k.
- RUN: each edge processes bit i=counter.
  - sub: d_i = a_i^b_i^br; br' = (~a_i&b_i) | (~(a_i^b_i)&br).
  - add: d_i = a_i^b_i^c; c' = (a_i&b_i) | ((a_i^b_i)&c).
  - d_i shifts into result reg from MSB side; operand regs shift right; counter++.
- Leaving RUN: at edge k+WIDTH (last bit) -> state=DONE; done=1; busy=0.
  - diff = result; borrow_out = final br/c.
  - overflow, sub: (a_msb!=b_msb) & (d_msb!=a_msb).
  - overflow, add: (a_msb==b_msb) & (d_msb!=a_msb).
  - Both use latched operands.
- DONE: unconditional -> IDLE at edge k+WIDTH+1; done=0.
- Latency: done high during the cycle after edge k+WIDTH; WIDTH+1 cycles from start sample to IDLE.
- Ignored inputs:
  - start while RUN or DONE: ignored, no queuing; a, b, mode changes during RUN do not affect the result.
  - start held high continuously: new op accepted at each return to IDLE (every WIDTH+2 cycles).
- Output hold: diff/borrow_out/overflow update only on the DONE transition; they hold through the next RUN.
- Reset mid-RUN: op aborted; all outputs 0; no done pulse.

Test Plan:
- WIDTH=8, mode=0, a=0x05, b=0x03, start 1 cycle -> busy 8 cycles, done pulse at edge k+8, diff=0x02, borrow_out=0, overflow=0.
- mode=0, a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0; a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
- mode=1, a=0xFF, b=0x01 -> diff=0x00, borrow_out=1, overflow=0; a=0x7F, b=0x01 -> diff=0x80, borrow_out=0, overflow=1.
- Pulse start again and change a/b mid-RUN -> no restart; result matches the first latched operands; done pulses exactly once.
- Assert rst_n=0 at cycle 4 of RUN -> immediate IDLE, all outputs 0, no done; next start after release completes correctly.
- WIDTH=3: all 64 a,b pairs, both modes -> diff=(a∓b) mod 8; borrow_out and overflow match the reference model.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-add/full-subtract cell reused LSB-first
// over WIDTH cycles, with start/busy/done handshake and held results.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             mode_q;
  logic             cb_q;
  logic [CNT_W-1:0] cnt;

  logic             a_bit;
  logic             b_bit;
  logic             x_bit;
  logic             d_bit;
  logic             cb_next;
  logic             ovf_c;
  logic             last_bit;

  // Single-bit cell: sum/difference, next carry/borrow and MSB overflow test
  always_comb begin
    a_bit    = a_sr[0];
    b_bit    = b_sr[0];
    x_bit    = a_bit ^ b_bit;
    d_bit    = x_bit ^ cb_q;
    cb_next  = 1'b0;
    ovf_c    = 1'b0;
    last_bit = (cnt == CNT_W'(WIDTH - 1));
    if (mode_q) begin
      cb_next = (a_bit & b_bit) | (x_bit & cb_q);
      ovf_c   = (a_bit == b_bit) & (d_bit != a_bit);
    end else begin
      cb_next = (~a_bit & b_bit) | (~x_bit & cb_q);
      ovf_c   = (a_bit != b_bit) & (d_bit != a_bit);
    end
  end

  // Control FSM, operand/result shifting and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      mode_q     <= 1'b0;
      cb_q       <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            mode_q <= mode;
            cb_q   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          cb_q   <= cb_next;
          cnt    <= cnt + CNT_W'(1);
          // After the last shift a_sr[0]/b_sr[0] hold the latched operand MSBs
          if (last_bit) begin
            diff       <= {d_bit, res_sr[WIDTH-1:1]};
            borrow_out <= cb_next;
            overflow   <= ovf_c;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub at WIDTH=8 and WIDTH=3 against an
// arithmetic reference model.
module tb_serial_add_sub;

  logic       clk;
  logic       rst_n;

  logic       start8, mode8, busy8, done8, bo8, ov8;
  logic [7:0] a8, b8, diff8;
  logic       start3, mode3, busy3, done3, bo3, ov3;
  logic [2:0] a3, b3, diff3;

  int checks;
  int failures;
  int prev_diff [2];

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_add_sub #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3), .overflow(ov3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void model(input int w, input bit m, input int av, input int bv,
                                output int d, output bit c, output bit v);
    int full, half, sa, sb, r;
    full = 1 << w;
    half = 1 << (w - 1);
    sa = (av >= half) ? av - full : av;
    sb = (bv >= half) ? bv - full : bv;
    if (m) begin
      d = (av + bv) % full;
      c = (av + bv) >= full;
      r = sa + sb;
    end else begin
      d = (av - bv + full) % full;
      c = av < bv;
      r = sa - sb;
    end
    v = (r < -half) || (r >= half);
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy3;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done3;
  endfunction
  function automatic logic [31:0] get_diff(input int w);
    return (w == 8) ? 32'(diff8) : 32'(diff3);
  endfunction
  function automatic logic get_bo(input int w);
    return (w == 8) ? bo8 : bo3;
  endfunction
  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov3;
  endfunction

  task automatic drive(input int w, input bit s, input bit m, input logic [7:0] av,
                       input logic [7:0] bv);
    if (w == 8) begin
      start8 = s; mode8 = m; a8 = av; b8 = bv;
    end else begin
      start3 = s; mode3 = m; a3 = av[2:0]; b3 = bv[2:0];
    end
  endtask

  task automatic set_start(input int w, input bit s);
    if (w == 8) start8 = s;
    else        start3 = s;
  endtask

  // One operation: start pulse, bounded wait for done, check latency/result/hold
  task automatic op(input int w, input bit m, input int av, input int bv, input bit scramble);
    int d, n, idx;
    bit c, v, seen, busy_ok;
    idx = (w == 8) ? 0 : 1;
    model(w, m, av, bv, d, c, v);
    @(posedge clk); #1;
    drive(w, 1'b1, m, 8'(av), 8'(bv));
    @(posedge clk); #1;
    set_start(w, 1'b0);
    chk("busy_after_start", 32'(get_busy(w)), 32'd1);
    chk("diff_hold_in_run", get_diff(w), 32'(prev_diff[idx]));
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 40) begin
      if (scramble) drive(w, n < 6, 1'($urandom), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      n++;
      if (get_done(w)) seen = 1;
      else if (!get_busy(w)) busy_ok = 0;
    end
    set_start(w, 1'b0);
    chk("done_latency", 32'(n), 32'(w));
    chk("busy_through_run", 32'(busy_ok), 32'd1);
    chk("busy_at_done", 32'(get_busy(w)), 32'd0);
    chk("diff", get_diff(w), 32'(d));
    chk("borrow_out", 32'(get_bo(w)), 32'(c));
    chk("overflow", 32'(get_ov(w)), 32'(v));
    prev_diff[idx] = d;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(get_done(w)), 32'd0);
    if (scramble) begin
      @(posedge clk); #1;
      chk("no_restart", 32'(get_busy(w) | get_done(w)), 32'd0);
    end
  endtask

  initial begin
    int n, gap, d;
    bit c, v, seen;
    checks = 0; failures = 0;
    prev_diff[0] = 0; prev_diff[1] = 0;
    rst_n = 1'b0;
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(3, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(bo8), 32'd0);
    chk("rst_ovf", 32'(ov8), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    op(8, 1'b0, 8'h05, 8'h03, 1'b0);
    op(8, 1'b0, 8'h03, 8'h05, 1'b0);
    op(8, 1'b0, 8'h80, 8'h01, 1'b0);
    op(8, 1'b1, 8'hFF, 8'h01, 1'b0);
    op(8, 1'b1, 8'h7F, 8'h01, 1'b0);
    // Mid-run start pulses and operand changes must be ignored
    op(8, 1'b0, 8'hA5, 8'h3C, 1'b1);
    op(8, 1'b1, 8'h80, 8'h80, 1'b1);

    // Randomized operations
    for (int i = 0; i < 40; i++)
      op(8, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
         1'($urandom_range(0, 3) == 0));

    // Start held high: back-to-back ops every WIDTH+2 cycles
    model(8, 1'b1, 8'h12, 8'h34, d, c, v);
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b1, 8'h12, 8'h34);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (done8) seen = 1;
    end
    chk("cont_first_done", 32'(seen), 32'd1);
    gap = 0; seen = 0;
    while (!seen && gap < 40) begin
      @(posedge clk); #1; gap++;
      if (done8) seen = 1;
    end
    start8 = 1'b0;
    chk("cont_period", 32'(gap), 32'd10);
    chk("cont_diff", 32'(diff8), 32'(d));
    prev_diff[0] = d;
    repeat (3) @(posedge clk);

    // Leave a non-zero result, then abort an op with reset on cycle 4 of RUN
    op(8, 1'b0, 8'h80, 8'h01, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b0, 8'h40, 8'h11);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_borrow", 32'(bo8), 32'd0);
    chk("abort_ovf", 32'(ov8), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done8) seen = 1;
      if (i == 1) rst_n = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    prev_diff[0] = 0; prev_diff[1] = 0;
    op(8, 1'b0, 8'h40, 8'h11, 1'b0);

    // Exhaustive WIDTH=3, both modes
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++)
          op(3, 1'(m), x, y, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
